// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single SRAM port: data side has priority,
// fetch is protected from starvation, one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                owner_d;
    logic [STARVE_W-1:0] starve;

    logic grant_d;
    logic grant_i;
    logic fetch_due;
    logic rd_done;

    // Read data is passed straight through; only rvalid qualifies it.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Arbitration: only in IDLE and never while reset is asserted.
    always_comb begin
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        fetch_due = i_req && (starve == STARVE_W'(MAX_STARVE));
        rd_done   = rst && (state == WAIT) && (cnt == CNT_W'(0));
        if (rst && (state == IDLE)) begin
            if (d_req && !fetch_due) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // SRAM request mux and handshake/return pulses.
    always_comb begin
        i_ready   = grant_i;
        d_ready   = grant_d;
        mem_en    = grant_i || grant_d;
        mem_wen   = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (grant_d) begin
            mem_wen   = d_wen;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_i) begin
            mem_addr  = i_addr;
        end
        i_rvalid = rd_done && !owner_d;
        d_rvalid = rd_done && owner_d;
    end

    // Transaction tracking, latency countdown and starvation bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= CNT_W'(0);
            owner_d <= 1'b0;
            starve  <= STARVE_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        if (!i_req) begin
                            starve <= STARVE_W'(0);
                        end else if (starve != STARVE_W'(MAX_STARVE)) begin
                            starve <= starve + STARVE_W'(1);
                        end
                        if (d_wen == 4'd0) begin
                            state   <= WAIT;
                            owner_d <= 1'b1;
                            cnt     <= CNT_W'(READ_LAT - 1);
                        end
                    end else if (grant_i) begin
                        starve  <= STARVE_W'(0);
                        state   <= WAIT;
                        owner_d <= 1'b0;
                        cnt     <= CNT_W'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(0)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM data port (mem_en/mem_wen/mem_addr/mem_wdata/mem_rdata) between two requesters: the instruction-fetch requester (i_*) and the memory-stage load/store requester (d_*).
- Data side has priority. A starvation counter guarantees fetch progress.
- Keeps one transaction in flight, tracks fixed SRAM read latency, and routes the returning read data to the owner.
- Sits between the memory stage, the fetch unit and the SRAM interface.

Parameters:
- READ_LAT, 1, SRAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- MAX_STARVE, 3, maximum consecutive data grants while i_req is pending; the next grant then goes to fetch. Legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  fetch read request; held with i_addr stable until i_ready.
- i_addr  in  32  fetch word address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse; i_rdata is valid.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; held with d_* stable until d_ready.
- d_wen  in  4  byte write enables; 0 means read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data, already lane-aligned.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; d_rdata is valid; reads only.
- d_rdata  out  32  data read data.
- mem_en  out  1  SRAM enable.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  32  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid READ_LAT cycles after a read mem_en.

Behaviour:
- Reset (rst=0 at an edge):
  - State=IDLE; latency counter=0; owner=none; starve counter=0.
  - All 1-bit outputs, mem_wen, mem_addr and mem_wdata are 0 while rst=0.
  - i_rdata/d_rdata are combinational copies of mem_rdata, not reset; they are meaningful only with rvalid.
- States:
  - IDLE: can accept a request.
  - WAIT: read outstanding; counter counts down from READ_LAT-1.
- Arbitration is combinational in IDLE only:
  - Winner = data if d_req and not (i_req and starve==MAX_STARVE).
  - Otherwise winner = fetch if i_req.
  - Otherwise no winner.
- Grant cycle T:
  - The winner's ready=1 and mem_en=1.
  - mem_addr = winner address. mem_wen = d_wen for data, 0 for fetch. mem_wdata = d_wdata for data, 0 for fetch.
  - Without a grant, mem_en=0 and mem_wen/mem_addr/mem_wdata=0.
- Write grant (data, d_wen≠0):
  - Completes in T; no rvalid.
  - State stays IDLE, so a new grant is allowed at T+1.
- Read grant (fetch, or data with d_wen=0):
  - Owner latched; state→WAIT at T+1; counter=READ_LAT-1.
  - In WAIT: no grants; all ready=0; mem_en=0; counter decrements each cycle.
  - In the cycle the counter is 0 (cycle T+READ_LAT): owner's rvalid=1, rdata=mem_rdata; next state IDLE.
  - Next grant is possible at T+READ_LAT+1.
  - When READ_LAT=1, WAIT lasts exactly one cycle.
- Starve counter, updated on grants only:
  - Data grant with i_req=1: increment, saturating at MAX_STARVE.
  - Fetch grant: clear to 0.
  - Data grant with i_req=0: clear to 0.
- Simultaneous requests:
  - Data wins until starve==MAX_STARVE, then fetch wins once.
  - The loser's ready stays 0 and its request stays held.
- Requester dropping req before ready: legal. No state change; nothing latched.
- Reset mid-WAIT:
  - Outstanding read abandoned; no rvalid pulse is produced, even if mem_rdata returns.
  - Starve counter cleared.
- Only one of i_ready/d_ready is high in any cycle, and only one of i_rvalid/d_rvalid.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_req=d_req=1 → all ready/rvalid/mem_en=0; first grant at the cycle after rst rises goes to data.
- Single fetch (READ_LAT=1): i_req, i_addr=0x0000_0100 at T → i_ready=1, mem_en=1, mem_addr=0x100, mem_wen=0 at T; SRAM returns 0xDEAD_BEEF at T+1 → i_rvalid=1, i_rdata=0xDEADBEEF at T+1; next grant possible at T+2.
- Back-to-back data: store d_wen=4'b0011, d_addr=0x200, d_wdata=0x1234_5678 at T, then load 0x200 at T+1 → mem_wen=0011 at T, d_ready at T+1, d_rvalid at T+2; no d_rvalid for the store.
- Starvation (MAX_STARVE=2, READ_LAT=1): i_req and d_req held continuously → grant owners D,D,I,D,D,I… at grant cycles spaced 2 apart.
- Latency (READ_LAT=3): fetch granted at T → mem_en only at T; i_rvalid at T+3; i_ready/d_ready=0 during T+1..T+3; next grant at T+4.
- Reset mid-WAIT (READ_LAT=3): fetch granted at T, rst=0 at T+1 → no i_rvalid at T+3; state IDLE; pending d_req granted on the first cycle after rst=1.
